// File: rtl/trap_sequencer_if.sv
// Bus between trap sources / datapath (master) and trap_sequencer (slave).
// dp_ack handshake: a level qualified only while the sequencer sits in WAIT_ACK; ignored in all other states.
interface trap_sequencer_if #(
    parameter int NREQ = 6,
    parameter int TTW  = 3
);
    logic [NREQ-1:0] trap_req;
    logic            et;
    logic            dp_ack;
    logic [TTW-1:0]  tt;
    logic            tt_load;
    logic            psr_save;
    logic            et_clear;
    logic            pc_vector;
    logic            busy;
    logic [NREQ-1:0] pending;
    logic            error_mode;
    logic [2:0]      state_dbg;

    modport master (
        output trap_req, et, dp_ack,
        input  tt, tt_load, psr_save, et_clear, pc_vector, busy, pending, error_mode, state_dbg
    );

    modport slave (
        input  trap_req, et, dp_ack,
        output tt, tt_load, psr_save, et_clear, pc_vector, busy, pending, error_mode, state_dbg
    );
endinterface

// File: rtl/trap_sequencer.sv
// SPARC trap entry sequencer: sticky pending requests, priority encode, TBR/PSR/PC strobe sequence.
// Optional macro TRAP_SEQ_ERROR_MODE_EN: a trap pending with ET=0 halts the processor in ERROR.
module trap_sequencer #(
    parameter int NREQ = 6,
    parameter int TTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    trap_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAVE     = 3'd1,
        VECTOR   = 3'd2,
`ifdef TRAP_SEQ_ERROR_MODE_EN
        WAIT_ACK = 3'd3,
        ERROR    = 3'd4
`else
        WAIT_ACK = 3'd3
`endif
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [TTW-1:0]  tt_q;
    logic            tt_load_q, psr_save_q, et_clear_q, pc_vector_q, busy_q;
    logic [NREQ-1:0] low_bit, clr_mask;
    logic [TTW-1:0]  enc;
    logic            take;
`ifdef TRAP_SEQ_ERROR_MODE_EN
    logic            err_q;
`endif

    always_comb begin
        enc = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending_q[i]) enc = TTW'(i);
        end
        // Two's-complement trick isolates the lowest set bit as the one-hot clear mask.
        low_bit   = pending_q & (~pending_q + NREQ'(1));
        take      = (state_q == IDLE) && (|pending_q) && bus.et;
        clr_mask  = take ? low_bit : '0;
        pending_d = (pending_q & ~clr_mask) | bus.trap_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            tt_q        <= '0;
            tt_load_q   <= 1'b0;
            psr_save_q  <= 1'b0;
            et_clear_q  <= 1'b0;
            pc_vector_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef TRAP_SEQ_ERROR_MODE_EN
            err_q       <= 1'b0;
`endif
        end else begin
            pending_q   <= pending_d;
            tt_load_q   <= 1'b0;
            psr_save_q  <= 1'b0;
            et_clear_q  <= 1'b0;
            pc_vector_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q    <= SAVE;
                        tt_q       <= enc;
                        tt_load_q  <= 1'b1;
                        psr_save_q <= 1'b1;
                        et_clear_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
`ifdef TRAP_SEQ_ERROR_MODE_EN
                    else if (|pending_q) begin
                        state_q <= ERROR;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
`endif
                end
                SAVE: begin
                    state_q     <= VECTOR;
                    pc_vector_q <= 1'b1;
                end
                VECTOR: begin
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.dp_ack) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`ifdef TRAP_SEQ_ERROR_MODE_EN
                ERROR: begin
                    state_q <= ERROR;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tt        = tt_q;
    assign bus.tt_load   = tt_load_q;
    assign bus.psr_save  = psr_save_q;
    assign bus.et_clear  = et_clear_q;
    assign bus.pc_vector = pc_vector_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.state_dbg = state_q;
`ifdef TRAP_SEQ_ERROR_MODE_EN
    assign bus.error_mode = err_q;
`else
    assign bus.error_mode = 1'b0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized traffic against a
// trap-entry model that tracks pending requests as a bit set and the entry as a cycle count.
module tb_trap_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    trap_sequencer_if #(.NREQ(6), .TTW(3)) bus ();

    trap_sequencer #(.NREQ(6), .TTW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_seq counts cycles since trap entry (0 = not sequencing).
    logic [5:0] m_pend;
    logic [2:0] m_tt;
    int         m_seq;
    bit         m_err;

    function automatic int low_idx(input logic [5:0] p);
        int idx;
        idx = 0;
        for (int i = 5; i >= 0; i--) if (p[i]) idx = i;
        return idx;
    endfunction

    function automatic logic [14:0] obs_vec();
        return {bus.tt, bus.tt_load, bus.psr_save, bus.et_clear, bus.pc_vector,
                bus.busy, bus.pending, bus.error_mode};
    endfunction

    function automatic logic [14:0] exp_vec();
        logic s1, s2;
        s1 = (m_seq == 1);
        s2 = (m_seq == 2);
        return {m_tt, s1, s1, s1, s2, (m_seq != 0) || m_err, m_pend, m_err};
    endfunction

    task automatic model_clear();
        m_pend = '0;
        m_tt   = '0;
        m_seq  = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        logic [5:0] clr;
        logic       cap;
        cap = (m_seq == 0) && !m_err && (m_pend != 0) && bus.et;
        clr = cap ? (6'd1 << low_idx(m_pend)) : 6'd0;
`ifdef TRAP_SEQ_ERROR_MODE_EN
        if ((m_seq == 0) && !m_err && (m_pend != 0) && !bus.et) m_err = 1'b1;
`endif
        if (cap) begin
            m_tt  = 3'(low_idx(m_pend));
            m_seq = 1;
        end else if (m_seq == 1 || m_seq == 2) begin
            m_seq = m_seq + 1;
        end else if (m_seq == 3 && bus.dp_ack) begin
            m_seq = 0;
        end
        m_pend = (m_pend & ~clr) | bus.trap_req;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else model_step();
        #1;
    endtask

    // Runs VECTOR, WAIT_ACK and an immediate ack starting from the SAVE cycle.
    task automatic finish_service();
        tick();
        tick();
        bus.dp_ack = 1'b1;
        tick();
        bus.dp_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        tick();
        n_cmp++;
        if (obs_vec() !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bus.et = 1'b1;
        bus.trap_req = 6'b000100;
        tick();
        n_cmp++;
        if (bus.pending !== 6'b000100 || bus.tt_load !== 1'b0) begin
            n_bad++;
            $display("FAIL single_capture: got pend=%b tt_load=%b expected 000100/0", bus.pending, bus.tt_load);
        end
        bus.trap_req = 6'b0;
        tick();
        n_cmp++;
        if ({bus.tt, bus.tt_load, bus.psr_save, bus.et_clear, bus.pending} !== {3'd2, 3'b111, 6'b0}) begin
            n_bad++;
            $display("FAIL single_save: got tt=%0d strobes=%b%b%b pend=%b expected 2/111/000000",
                     bus.tt, bus.tt_load, bus.psr_save, bus.et_clear, bus.pending);
        end
        tick();
        n_cmp++;
        if (bus.pc_vector !== 1'b1 || bus.tt_load !== 1'b0) begin
            n_bad++;
            $display("FAIL single_vector: got pc_vector=%b tt_load=%b expected 1/0", bus.pc_vector, bus.tt_load);
        end
        tick();
        bus.dp_ack = 1'b1;
        tick();
        bus.dp_ack = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_priority();
        bus.trap_req = 6'b101000;
        tick();
        bus.trap_req = 6'b0;
        tick();
        n_cmp++;
        if (bus.tt !== 3'd3 || bus.pending !== 6'b100000 || bus.tt_load !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_first: got tt=%0d pend=%b tt_load=%b expected 3/100000/1", bus.tt, bus.pending, bus.tt_load);
        end
        bus.et = 1'b0;
        tick();
        tick();
        bus.dp_ack = 1'b1;
        bus.et = 1'b1;
        tick();
        bus.dp_ack = 1'b0;
        tick();
        n_cmp++;
        if (bus.tt !== 3'd5 || bus.tt_load !== 1'b1 || bus.pending !== 6'b0) begin
            n_bad++;
            $display("FAIL prio_second: got tt=%0d tt_load=%b pend=%b expected 5/1/000000", bus.tt, bus.tt_load, bus.pending);
        end
        finish_service();
    endtask

    task automatic test_accumulate();
        bus.trap_req = 6'b010000;
        tick();
        bus.trap_req = 6'b0;
        tick();
        tick();
        tick();
        bus.trap_req = 6'b000001;
        tick();
        bus.trap_req = 6'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.tt_load, bus.pc_vector, bus.busy, bus.pending, bus.tt} !== {3'b001, 6'b000001, 3'd4}) begin
            n_bad++;
            $display("FAIL accum_hold: got tt_load=%b pc_vector=%b busy=%b pend=%b tt=%0d expected 0/0/1/000001/4",
                     bus.tt_load, bus.pc_vector, bus.busy, bus.pending, bus.tt);
        end
        bus.dp_ack = 1'b1;
        tick();
        bus.dp_ack = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.tt_load !== 1'b0) begin
            n_bad++;
            $display("FAIL accum_idle: got busy=%b tt_load=%b expected 0/0", bus.busy, bus.tt_load);
        end
        tick();
        n_cmp++;
        if (bus.tt !== 3'd0 || bus.tt_load !== 1'b1) begin
            n_bad++;
            $display("FAIL accum_service: got tt=%0d tt_load=%b expected 0/1", bus.tt, bus.tt_load);
        end
        finish_service();
    endtask

    task automatic test_same_bit();
        bus.trap_req = 6'b000010;
        tick();
        tick();
        bus.trap_req = 6'b0;
        n_cmp++;
        if (bus.pending !== 6'b000010 || bus.tt !== 3'd1 || bus.tt_load !== 1'b1) begin
            n_bad++;
            $display("FAIL same_bit_keep: got pend=%b tt=%0d tt_load=%b expected 000010/1/1", bus.pending, bus.tt, bus.tt_load);
        end
        finish_service();
        tick();
        n_cmp++;
        if (bus.tt_load !== 1'b1 || bus.tt !== 3'd1 || bus.pending !== 6'b0) begin
            n_bad++;
            $display("FAIL same_bit_second: got tt_load=%b tt=%0d pend=%b expected 1/1/000000", bus.tt_load, bus.tt, bus.pending);
        end
        finish_service();
    endtask

    task automatic test_back_to_back();
        int gap;
        bus.trap_req = 6'b000011;
        bus.dp_ack = 1'b1;
        tick();
        bus.trap_req = 6'b0;
        tick();
        gap = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            gap++;
            if (bus.tt_load === 1'b1) break;
        end
        bus.dp_ack = 1'b0;
        n_cmp++;
        if (gap !== 4 || bus.tt !== 3'd1) begin
            n_bad++;
            $display("FAIL back_to_back: got gap=%0d tt=%0d expected 4/1", gap, bus.tt);
        end
        finish_service();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            bus.trap_req = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'b0;
`ifdef TRAP_SEQ_ERROR_MODE_EN
            bus.et = 1'b1;
`else
            bus.et = ($urandom_range(0, 4) != 0);
`endif
            bus.dp_ack = $urandom_range(0, 1) == 1;
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                errs++;
                if (errs < 10) $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        bus.trap_req = 6'b0;
        bus.et = 1'b1;
        bus.dp_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (m_seq == 0 && m_pend == 0) break;
            tick();
        end
        bus.dp_ack = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL random_drain: got %h expected %h idle", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_et_low();
        bus.et = 1'b0;
        bus.trap_req = 6'b001000;
        tick();
        bus.trap_req = 6'b0;
        tick();
`ifdef TRAP_SEQ_ERROR_MODE_EN
        n_cmp++;
        if ({bus.error_mode, bus.busy, bus.tt_load, bus.pc_vector} !== 4'b1100) begin
            n_bad++;
            $display("FAIL et_low_error: got err=%b busy=%b tt_load=%b pc_vector=%b expected 1/1/0/0",
                     bus.error_mode, bus.busy, bus.tt_load, bus.pc_vector);
        end
        bus.et = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({bus.error_mode, bus.busy, bus.tt_load, bus.pc_vector} !== 4'b1100) begin
            n_bad++;
            $display("FAIL et_low_sticky: got err=%b busy=%b tt_load=%b pc_vector=%b expected 1/1/0/0",
                     bus.error_mode, bus.busy, bus.tt_load, bus.pc_vector);
        end
`else
        tick();
        n_cmp++;
        if ({bus.error_mode, bus.busy, bus.tt_load, bus.pending} !== {3'b000, 6'b001000}) begin
            n_bad++;
            $display("FAIL et_low_wait: got err=%b busy=%b tt_load=%b pend=%b expected 0/0/0/001000",
                     bus.error_mode, bus.busy, bus.tt_load, bus.pending);
        end
        bus.et = 1'b1;
        tick();
        n_cmp++;
        if (bus.tt_load !== 1'b1 || bus.tt !== 3'd3) begin
            n_bad++;
            $display("FAIL et_low_resume: got tt_load=%b tt=%0d expected 1/3", bus.tt_load, bus.tt);
        end
        finish_service();
`endif
    endtask

    task automatic test_reset_vector();
        bus.et = 1'b1;
        bus.trap_req = 6'b100001;
        tick();
        bus.trap_req = 6'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.pc_vector !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_vec_pre: got pc_vector=%b expected 1", bus.pc_vector);
        end
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (obs_vec() !== 15'd0) begin
            n_bad++;
            $display("FAIL rst_vec_async: got %h expected 0", obs_vec());
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec() || bus.pc_vector !== 1'b0 || bus.pending !== 6'b0) begin
                n_bad++;
                $display("FAIL rst_vec_after%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.trap_req = 6'b0;
        bus.et = 1'b0;
        bus.dp_ack = 1'b0;
        model_clear();
        test_reset();
        test_single();
        test_priority();
        test_accumulate();
        test_same_bit();
        test_back_to_back();
        test_random();
        test_et_low();
        test_reset_vector();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
